// File: rtl/lzs_out_pack.sv
// lzs_out_pack
// Packs a stream of IN_W-bit encoder words into OUT_W-bit output words,
// first input word in the most significant slot. A completed word is moved
// to a single hold register that is written to the downstream FIFO as soon
// as it is not full. The final word of a stream (di_last) flushes any
// partial assembly, zero-padded in the unused low slots. The end of a
// stream is then marked with a one-cycle m_endn pulse.
//
// Parameters
//   IN_W   input word width (multiple of 8)
//   OUT_W  output word width, OUT_W/IN_W must be a power of two, 2..8
//   CNT_W  width of the output word counter
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   di          encoder output word
//   die         di valid (taken only while di_rdy is high)
//   di_last     di is the final word of the stream
//   di_rdy      packer can take di this cycle
//   dst_full    downstream FIFO full
//   m_dst       packed output word
//   m_dst_putn  active-low write strobe, one cycle per word
//   m_endn      active-low end-of-stream pulse
//   out_cnt     number of words written since reset (wrapping)
module lzs_out_pack #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 64,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  di,
    input  logic             die,
    input  logic             di_last,
    output logic             di_rdy,
    input  logic             dst_full,
    output logic [OUT_W-1:0] m_dst,
    output logic             m_dst_putn,
    output logic             m_endn,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int N   = OUT_W / IN_W;
    localparam int K_W = $clog2(N);

    typedef enum logic [1:0] {
        S_FILL,
        S_FLUSH,
        S_END
    } state_t;

    state_t           state;
    logic [K_W-1:0]   k;
    logic [OUT_W-1:0] assembly;
    logic [OUT_W-1:0] hold;
    logic             hold_v;

    logic             accept;
    logic             drain;
    logic             word_done;
    logic [OUT_W-1:0] assembly_ins;

    // The only place new input can be refused is a full hold register that
    // cannot drain; the flush/end states refuse input until the stream end
    // has been signalled.
    assign di_rdy = (state == S_FILL) && !(hold_v && dst_full);
    assign accept = die && di_rdy;

    // Writing is gated by rst so that a reset cycle never hands held data
    // to the FIFO.
    assign drain      = hold_v && !dst_full && !rst;
    assign m_dst_putn = !drain;
    assign m_dst      = hold;
    assign m_endn     = !((state == S_END) && !rst);

    // A word leaves the assembly either when its last slot is filled or when
    // the stream ends, whichever comes first. A complete word that is also
    // the last one therefore produces just that word, never a trailing zero.
    assign word_done = accept && ((k == K_W'(N - 1)) || di_last);

    // Current assembly with the incoming word dropped into slot k.
    always_comb begin
        assembly_ins = assembly;
        for (int s = 0; s < N; s++) begin
            if (k == K_W'(s)) begin
                assembly_ins[OUT_W-1-s*IN_W -: IN_W] = di;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FILL;
            k        <= '0;
            assembly <= '0;
            hold     <= '0;
            hold_v   <= 1'b0;
            out_cnt  <= '0;
        end else begin
            if (accept) begin
                if (word_done) begin
                    hold     <= assembly_ins;
                    assembly <= '0;
                    k        <= '0;
                end else begin
                    assembly <= assembly_ins;
                    k        <= k + 1'b1;
                end
            end

            // Loading is only possible when hold is empty or draining this
            // cycle, so a simultaneous drain and load keeps hold_v set.
            hold_v <= word_done || (hold_v && !drain);

            if (drain) begin
                out_cnt <= out_cnt + 1'b1;
            end

            case (state)
                S_FILL: begin
                    if (accept && di_last) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // The last word already sits in hold; leave once it is
                    // gone (or goes on this edge).
                    if (!hold_v || drain) begin
                        state <= S_END;
                    end
                end
                S_END: begin
                    state <= S_FILL;
                    k     <= '0;
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzs_out_pack.sv
// tb_lzs_out_pack
// Self-checking bench for lzs_out_pack. A default-parameter instance is
// driven with directed and random streams (random gaps, random downstream
// back-pressure) and every write is checked against a queue of packed words
// built from the accepted input words. A second instance (IN_W=32, CNT_W=4)
// checks 32-bit packing and counter wrap.
module tb_lzs_out_pack;

    logic clk = 1'b0;

    // 10 time-unit clock shared by both instances
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] di;
    logic        die;
    logic        di_last;
    logic        di_rdy;
    logic        dst_full;
    logic [63:0] m_dst;
    logic        m_dst_putn;
    logic        m_endn;
    logic [19:0] out_cnt;

    logic [31:0] di2;
    logic        die2;
    logic        diLast2;
    logic        diRdy2;
    logic        dstFull2;
    logic [63:0] mDst2;
    logic        mDstPutn2;
    logic        mEndn2;
    logic [3:0]  outCnt2;

    lzs_out_pack dut (
        .clk        (clk),
        .rst        (rst),
        .di         (di),
        .die        (die),
        .di_last    (di_last),
        .di_rdy     (di_rdy),
        .dst_full   (dst_full),
        .m_dst      (m_dst),
        .m_dst_putn (m_dst_putn),
        .m_endn     (m_endn),
        .out_cnt    (out_cnt)
    );

    lzs_out_pack #(.IN_W(32), .OUT_W(64), .CNT_W(4)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .di         (di2),
        .die        (die2),
        .di_last    (diLast2),
        .di_rdy     (diRdy2),
        .dst_full   (dstFull2),
        .m_dst      (mDst2),
        .m_dst_putn (mDstPutn2),
        .m_endn     (mEndn2),
        .out_cnt    (outCnt2)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] expQ[$];
    logic [15:0] partial[$];
    int          endPending  = 0;
    int          expCnt      = 0;
    int          stallMode   = 0;
    logic [63:0] stallWord;

    int          writes2     = 0;
    int          ends2       = 0;
    logic [63:0] first2      = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference packer: collect accepted words, emit a 64-bit word of four
    // 16-bit fields (first word highest) when four are collected or the
    // stream ends, missing fields left zero.
    task automatic modelAccept(input logic [15:0] w, input logic l);
        logic [63:0] word;
        partial.push_back(w);
        if (partial.size() == 4 || l) begin
            word = '0;
            foreach (partial[i]) word = word | (64'(partial[i]) << (16 * (3 - i)));
            expQ.push_back(word);
            expCnt++;
            partial.delete();
        end
        if (l) endPending++;
    endtask

    // Offer one word and hold it until the packer takes it.
    task automatic applyStimulus(input logic [15:0] w, input logic l);
        int guard = 0;
        di      = w;
        di_last = l;
        die     = 1'b1;
        while (!di_rdy && guard < 500) begin
            @(posedge clk);
            #2;
            guard++;
        end
        checkOutput("accept_timeout", 64'(di_rdy), 64'd1);
        @(posedge clk);
        #2;
        modelAccept(w, l);
        die     = 1'b0;
        di_last = 1'b0;
    endtask

    task automatic idle(input int n);
        die = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        expQ.delete();
        partial.delete();
        endPending = 0;
        expCnt     = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_putn"}, 64'(m_dst_putn), 64'd1);
        checkOutput({tag, "_endn"}, 64'(m_endn), 64'd1);
        checkOutput({tag, "_rdy"}, 64'(di_rdy), 64'd1);
        checkOutput({tag, "_dst"}, m_dst, 64'd0);
        checkOutput({tag, "_cnt"}, 64'(out_cnt), 64'd0);
    endtask

    // Wait (bounded) until every expected word and end pulse has appeared,
    // then check the write counter.
    task automatic waitQuiet(input string tag);
        int guard = 0;
        while ((expQ.size() != 0 || endPending != 0) && guard < 500) begin
            @(posedge clk);
            #2;
            guard++;
        end
        checkOutput({tag, "_drain"}, 64'(expQ.size() + endPending), 64'd0);
        idle(3);
        checkOutput({tag, "_cnt"}, 64'(out_cnt), 64'(expCnt % (1 << 20)));
    endtask

    // Downstream back-pressure: off, random, or held full.
    always @(posedge clk) begin
        #1;
        case (stallMode)
            0:       dst_full = 1'b0;
            1:       dst_full = ($urandom_range(0, 99) < 35);
            default: dst_full = 1'b1;
        endcase
    end

    // Downstream side of the default instance: each write must match the
    // next expected word, each end pulse must follow the stream's last write.
    always @(negedge clk) begin
        if (!m_dst_putn) begin
            checkOutput("write_pending", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) checkOutput("write_data", m_dst, expQ.pop_front());
        end
        if (!m_endn) begin
            checkOutput("end_expected", 64'(endPending > 0), 64'd1);
            checkOutput("end_after_drain", 64'(expQ.size()), 64'd0);
            if (endPending > 0) endPending--;
        end
    end

    // Downstream side of the 32-bit instance.
    always @(negedge clk) begin
        if (!mDstPutn2) begin
            if (writes2 == 0) first2 = mDst2;
            writes2++;
        end
        if (!mEndn2) ends2++;
    end

    // Overall time limit so the bench always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset checks, 32-bit instance, directed cases, random.
    initial begin
        int len;
        rst      = 1'b1;
        di       = '0;
        die      = 1'b0;
        di_last  = 1'b0;
        dst_full = 1'b0;
        di2      = '0;
        die2     = 1'b0;
        diLast2  = 1'b0;
        dstFull2 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        doReset();
        checkResetState("reset");

        // 32-bit input: 34 words, 17 output words, 4-bit counter wraps to 1
        for (int i = 0; i < 34; i++) begin
            checkOutput("w32_rdy", 64'(diRdy2), 64'd1);
            di2     = (i == 0) ? 32'h11223344 : (i == 1) ? 32'h55667788 : $urandom;
            diLast2 = (i == 33);
            die2    = 1'b1;
            @(posedge clk);
            #2;
        end
        die2    = 1'b0;
        diLast2 = 1'b0;
        idle(6);
        checkOutput("w32_first", first2, 64'h1122334455667788);
        checkOutput("w32_writes", 64'(writes2), 64'd17);
        checkOutput("w32_cnt", 64'(outCnt2), 64'd1);
        checkOutput("w32_ends", 64'(ends2), 64'd1);

        // eight back-to-back words, two full output words
        for (int i = 0; i < 8; i++) applyStimulus({8'(2 * i + 1), 8'(2 * i + 2)}, 1'b0);
        idle(3);
        checkOutput("b2b_cnt", 64'(out_cnt), 64'd2);
        checkOutput("b2b_left", 64'(expQ.size()), 64'd0);

        // short stream, zero-padded flush
        doReset();
        applyStimulus(16'hAAAA, 1'b0);
        applyStimulus(16'hBBBB, 1'b0);
        applyStimulus(16'hCCCC, 1'b1);
        waitQuiet("partial");
        checkOutput("partial_cnt1", 64'(out_cnt), 64'd1);

        // last word on the final slot: one word only
        for (int i = 0; i < 4; i++) applyStimulus(16'h1000 + 16'(i), i == 3);
        waitQuiet("full_last");

        // held word while downstream stays full
        stallMode = 2;
        idle(1);
        for (int i = 0; i < 4; i++) applyStimulus(16'h2000 + 16'(i), 1'b0);
        checkOutput("stall_hold", 64'(expQ.size()), 64'd1);
        stallWord = (expQ.size() > 0) ? expQ[0] : '0;
        repeat (10) begin
            @(negedge clk);
            checkOutput("stall_putn", 64'(m_dst_putn), 64'd1);
            checkOutput("stall_rdy", 64'(di_rdy), 64'd0);
            checkOutput("stall_data", m_dst, stallWord);
        end
        @(posedge clk);
        #2;
        stallMode = 0;
        for (int i = 0; i < 5; i++) applyStimulus(16'h3000 + 16'(i), i == 4);
        waitQuiet("stall_release");

        // reset with two words in the assembly
        doReset();
        applyStimulus(16'h4444, 1'b0);
        applyStimulus(16'h5555, 1'b0);
        idle(1);
        doReset();
        checkResetState("rst_mid");
        for (int i = 0; i < 4; i++) applyStimulus(16'h6000 + 16'(i), 1'b0);
        idle(3);
        checkOutput("rst_mid_clean", 64'(out_cnt), 64'd1);

        // reset with a held word during a stall
        stallMode = 2;
        idle(1);
        for (int i = 0; i < 4; i++) applyStimulus(16'h7000 + 16'(i), 1'b0);
        idle(3);
        doReset();
        stallMode = 0;
        idle(2);
        checkResetState("rst_stall");

        // random streams with random gaps and back-pressure
        stallMode = 1;
        for (int s = 0; s < 40; s++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                applyStimulus(16'($urandom), i == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        stallMode = 0;
        waitQuiet("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
